// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master data memory arbiter (IDLE/ACCESS/ACK), one RAM access per grant.
// Optional round-robin tie-break on simultaneous requests: define DMEM_ARB_RR_EN.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_sel,
    output logic              ram_str,
    output logic              ram_ld,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t              state, state_nx;
    logic                grant_id;
    logic                lat_id;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                any_req;

    assign any_req = m0_req | m1_req;

`ifdef DMEM_ARB_RR_EN
    // Stores "m0 was granted last"; reset value 0 means m1 is treated as last, so m0 wins the first tie.
    logic last_m0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            last_m0 <= 1'b0;
        else if (state == IDLE && any_req)
            last_m0 <= ~grant_id;
    end

    always_comb begin
        if (m0_req && m1_req)
            grant_id = last_m0;
        else
            grant_id = ~m0_req;
    end
`else
    always_comb begin
        grant_id = ~m0_req;
    end
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && any_req) begin
            lat_id    <= grant_id;
            lat_we    <= grant_id ? m1_we    : m0_we;
            lat_addr  <= grant_id ? m1_addr  : m0_addr;
            lat_wdata <= grant_id ? m1_wdata : m0_wdata;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            rdata <= '0;
        else if (state == ACCESS && !lat_we)
            rdata <= ram_rdata;
    end

    // Strobes decode from state and latched registers only, so clr removes them asynchronously.
    always_comb begin
        state_nx  = state;
        ram_sel   = 1'b0;
        ram_str   = 1'b0;
        ram_ld    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nx = ACCESS;
            end
            ACCESS: begin
                ram_sel   = 1'b1;
                ram_str   = lat_we;
                ram_ld    = ~lat_we;
                ram_addr  = lat_addr;
                ram_wdata = lat_wdata;
                state_nx  = ACK;
            end
            ACK: begin
                m0_ack   = ~lat_id;
                m1_ack   = lat_id;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter against a memory/arbitration model.
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_ack, m1_ack, ram_sel, ram_str, ram_ld, busy;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] model_rdata;
    int            model_last;
    int            checks = 0;
    int            fails = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .clr(clr),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
        .rdata(rdata), .ram_sel(ram_sel), .ram_str(ram_str), .ram_ld(ram_ld),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    assign ram_rdata = (ram_sel && ram_ld) ? mem[ram_addr] : '0;

    always @(posedge clk) begin
        if (ram_sel && ram_str)
            mem[ram_addr] <= ram_wdata;
    end

    task automatic set_master(input int m, input logic rq, input logic we,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m == 0) begin
            m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic do_access(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        set_master(m, 1'b1, we, a, d);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, ram_sel, ram_str, ram_ld, m0_ack, m1_ack} !== {1'b1, 1'b1, we, ~we, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL access_strobes m%0d: busy/sel/str/ld/ack0/ack1 got %b want %b", m,
                     {busy, ram_sel, ram_str, ram_ld, m0_ack, m1_ack}, {1'b1, 1'b1, we, ~we, 1'b0, 1'b0});
        end
        checks++;
        if (ram_addr !== a || (we && ram_wdata !== d)) begin
            fails++;
            $display("FAIL access_addr m%0d: addr %0d data %h want addr %0d data %h", m, ram_addr, ram_wdata, a, d);
        end
        set_master(m, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
        #1;
        checks++;
        if (ram_addr !== a || ram_str !== we) begin
            fails++;
            $display("FAIL input_isolation m%0d: addr %0d str %b want addr %0d str %b", m, ram_addr, ram_str, a, we);
        end
        @(posedge clk);
        if (we) ref_mem[a] = d;
        else    model_rdata = ref_mem[a];
        model_last = m;
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack} !== {m == 0, m == 1} || rdata !== model_rdata) begin
            fails++;
            $display("FAIL ack_cycle m%0d: ack0/ack1 %b%b rdata %h want %b%b rdata %h", m, m0_ack, m1_ack,
                     rdata, m == 0, m == 1, model_rdata);
        end
        checks++;
        if ({ram_sel, ram_str, ram_ld} !== 3'b000 || ram_addr !== '0 || ram_wdata !== '0) begin
            fails++;
            $display("FAIL ack_ram_idle m%0d: sel/str/ld %b addr %0d wdata %h want 000 0 0", m,
                     {ram_sel, ram_str, ram_ld}, ram_addr, ram_wdata);
        end
        set_master(m, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, m0_ack, m1_ack} !== 3'b000) begin
            fails++;
            $display("FAIL back_idle m%0d: busy/ack0/ack1 %b want 000", m, {busy, m0_ack, m1_ack});
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, m0_ack, m1_ack, ram_sel, ram_str, ram_ld} !== 6'b0 || rdata !== '0 ||
            ram_addr !== '0 || ram_wdata !== '0) begin
            fails++;
            $display("FAIL reset_state: flags %b rdata %h addr %0d wdata %h want all 0",
                     {busy, m0_ack, m1_ack, ram_sel, ram_str, ram_ld}, rdata, ram_addr, ram_wdata);
        end
        clr = 1'b0;
        model_rdata = '0;
        model_last = 1;
    endtask

    task automatic test_write_read();
        do_access(0, 1'b1, AW'(5), 32'hDEADBEEF);
        do_access(1, 1'b0, AW'(5), '0);
        checks++;
        if (model_rdata !== 32'hDEADBEEF || mem[5] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_read_5: ram word %h want deadbeef", mem[5]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            do_access(int'($urandom_range(1)), 1'($urandom), AW'($urandom_range(15)), DW'($urandom));
    endtask

    task automatic test_contention();
        int          grants = 0;
        int          expw;
        logic [DW-1:0] d0, d1;
        d0 = DW'($urandom);
        d1 = DW'($urandom);
        @(negedge clk);
        set_master(0, 1'b1, 1'b1, AW'(20), d0);
        set_master(1, 1'b1, 1'b1, AW'(21), d1);
        for (int c = 0; c < 60 && grants < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (m0_ack || m1_ack) begin
`ifdef DMEM_ARB_RR_EN
                expw = 1 - model_last;
`else
                expw = 0;
`endif
                checks++;
                if ({m0_ack, m1_ack} !== {expw == 0, expw == 1}) begin
                    fails++;
                    $display("FAIL contention_order grant %0d: ack0/ack1 %b%b want %b%b", grants,
                             m0_ack, m1_ack, expw == 0, expw == 1);
                end
                model_last = expw;
                if (expw == 0) ref_mem[20] = d0;
                else           ref_mem[21] = d1;
                grants++;
                if (grants == 4) begin
                    set_master(0, 1'b0, 1'b0, '0, '0);
                    set_master(1, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        checks++;
        if (grants != 4) begin
            fails++;
            $display("FAIL contention_timeout: grants %0d want 4", grants);
            set_master(0, 1'b0, 1'b0, '0, '0);
            set_master(1, 1'b0, 1'b0, '0, '0);
        end
        repeat (3) @(negedge clk);
        do_access(1, 1'b0, AW'(20), '0);
        do_access(0, 1'b0, AW'(21), '0);
    endtask

    task automatic test_clr_mid_access();
        do_access(0, 1'b1, AW'(9), 32'h5555AAAA);
        @(negedge clk);
        set_master(0, 1'b1, 1'b1, AW'(9), 32'h00001234);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ram_str !== 1'b1 || ram_addr !== AW'(9)) begin
            fails++;
            $display("FAIL clr_pre_access: str %b addr %0d want 1 9", ram_str, ram_addr);
        end
        clr = 1'b1;
        set_master(0, 1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if ({ram_sel, ram_str, ram_ld, busy} !== 4'b0 || rdata !== '0) begin
            fails++;
            $display("FAIL clr_drop: sel/str/ld/busy %b rdata %h want 0000 0", {ram_sel, ram_str, ram_ld, busy}, rdata);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack, busy} !== 3'b000) begin
            fails++;
            $display("FAIL clr_no_ack: ack0/ack1/busy %b want 000", {m0_ack, m1_ack, busy});
        end
        clr = 1'b0;
        model_rdata = '0;
        model_last = 1;
        do_access(1, 1'b0, AW'(9), '0);
        checks++;
        if (model_rdata !== 32'h5555AAAA) begin
            fails++;
            $display("FAIL clr_aborted_write: read %h want 5555aaaa", model_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        model_rdata = '0;
        model_last = 1;
        test_reset();
        test_write_read();
        test_random();
        test_contention();
        test_clr_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
